cart_mem_responder: RTL and testbench

Memory-side responder for the cartridge bus driven by the mapper mux: accepts the ROM and BSRAM strobe-style accesses (`rom_*`, `bsram_*`) produced by whichever mapper is active and serves them from a single shared 16-bit backing memory through a req/ack handshake. It detects new accesses from address and strobe changes, arbitrates ROM against BSRAM, and keeps a one-word ROM read buffer so that repeated fetches of the same word do not reach the backing memory. It sits between the SNES core top level and the board SDRAM controller.

---
 rtl/cart_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_cart_mem_responder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cart_mem_responder.sv
// Serves cartridge ROM/BSRAM strobe accesses from one shared 16-bit memory over a req/ack handshake.
// Miss: mem_req one edge after detection, data captured on the ack edge; ROM buffer hit returns one edge after detection.
module cart_mem_responder #(
  parameter logic        CACHE_EN   = 1'b1,
  parameter logic [24:0] BSRAM_BASE = 25'h1000000
) (
  input  logic        mclk,
  input  logic        rst_n,
  input  logic [23:0] rom_addr,
  input  logic [15:0] rom_d,
  input  logic        rom_ce_n,
  input  logic        rom_oe_n,
  input  logic        rom_we_n,
  input  logic        rom_word,
  output logic [15:0] rom_q,
  input  logic [19:0] bsram_addr,
  input  logic [7:0]  bsram_d,
  input  logic        bsram_ce_n,
  input  logic        bsram_oe_n,
  input  logic        bsram_we_n,
  output logic [7:0]  bsram_q,
  output logic        mem_req,
  output logic        mem_we,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ROM_ACC, BS_ACC} state_t;

  state_t      state_q, state_d;
  logic        rom_act_q, rom_act_d;
  logic [23:0] rom_prev_addr_q, rom_prev_addr_d;
  logic        rom_prev_we_n_q, rom_prev_we_n_d;
  logic        bs_act_q, bs_act_d;
  logic [19:0] bs_prev_addr_q, bs_prev_addr_d;
  logic        bs_prev_we_n_q, bs_prev_we_n_d;
  logic        rom_pend_q, rom_pend_d;
  logic [23:0] rom_p_addr_q, rom_p_addr_d;
  logic [15:0] rom_p_data_q, rom_p_data_d;
  logic        rom_p_we_q, rom_p_we_d;
  logic        rom_p_word_q, rom_p_word_d;
  logic        bs_pend_q, bs_pend_d;
  logic [19:0] bs_p_addr_q, bs_p_addr_d;
  logic [7:0]  bs_p_data_q, bs_p_data_d;
  logic        bs_p_we_q, bs_p_we_d;
  logic        cur_sel_q, cur_sel_d;
  logic        cur_word_q, cur_word_d;
  logic        cur_we_q, cur_we_d;
  logic [22:0] cur_tag_q, cur_tag_d;
  logic        buf_vld_q, buf_vld_d;
  logic [22:0] buf_tag_q, buf_tag_d;
  logic [15:0] buf_data_q, buf_data_d;
  logic        hit_pend_q, hit_pend_d;
  logic        hit_sel_q, hit_sel_d;
  logic        hit_word_q, hit_word_d;
  logic [15:0] rom_out_q, rom_out_d;
  logic [7:0]  bs_out_q, bs_out_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [24:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_be_q, mem_be_d;

  logic rom_act, bs_act, rom_new, bs_new, rom_hit;

  function automatic logic [15:0] rom_fmt(input logic [15:0] w, input logic word, input logic sel);
    if (word) return w;
    else if (sel) return {w[15:8], w[15:8]};
    else return {w[7:0], w[7:0]};
  endfunction

  function automatic logic [1:0] lane_be(input logic we, input logic word, input logic sel);
    if (!we || word) return 2'b11;
    else if (sel) return 2'b10;
    else return 2'b01;
  endfunction

  assign rom_act = !rom_ce_n && (!rom_oe_n || !rom_we_n);
  assign bs_act  = !bsram_ce_n && (!bsram_oe_n || !bsram_we_n);
  assign rom_new = rom_act && (!rom_act_q || (rom_addr != rom_prev_addr_q) || (rom_we_n != rom_prev_we_n_q));
  assign bs_new  = bs_act && (!bs_act_q || (bsram_addr != bs_prev_addr_q) || (bsram_we_n != bs_prev_we_n_q));
  assign rom_hit = CACHE_EN && rom_new && rom_we_n && buf_vld_q && (buf_tag_q == rom_addr[23:1]);

  always_comb begin
    state_d         = state_q;
    rom_act_d       = rom_act;
    rom_prev_addr_d = rom_addr;
    rom_prev_we_n_d = rom_we_n;
    bs_act_d        = bs_act;
    bs_prev_addr_d  = bsram_addr;
    bs_prev_we_n_d  = bsram_we_n;
    rom_pend_d      = rom_pend_q;
    rom_p_addr_d    = rom_p_addr_q;
    rom_p_data_d    = rom_p_data_q;
    rom_p_we_d      = rom_p_we_q;
    rom_p_word_d    = rom_p_word_q;
    bs_pend_d       = bs_pend_q;
    bs_p_addr_d     = bs_p_addr_q;
    bs_p_data_d     = bs_p_data_q;
    bs_p_we_d       = bs_p_we_q;
    cur_sel_d       = cur_sel_q;
    cur_word_d      = cur_word_q;
    cur_we_d        = cur_we_q;
    cur_tag_d       = cur_tag_q;
    buf_vld_d       = buf_vld_q;
    buf_tag_d       = buf_tag_q;
    buf_data_d      = buf_data_q;
    hit_pend_d      = hit_pend_q;
    hit_sel_d       = hit_sel_q;
    hit_word_d      = hit_word_q;
    rom_out_d       = rom_out_q;
    bs_out_d        = bs_out_q;
    mem_req_d       = mem_req_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_be_d        = mem_be_q;

    // The slot is released at issue; the in-flight context lives in cur_*, so a
    // detection arriving while the access is outstanding is never dropped.
    case (state_q)
      IDLE: begin
        if (rom_pend_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = rom_p_we_q;
          mem_addr_d  = {1'b0, rom_p_addr_q[23:1], 1'b0};
          mem_wdata_d = rom_p_word_q ? rom_p_data_q : {rom_p_data_q[7:0], rom_p_data_q[7:0]};
          mem_be_d    = lane_be(rom_p_we_q, rom_p_word_q, rom_p_addr_q[0]);
          cur_sel_d   = rom_p_addr_q[0];
          cur_word_d  = rom_p_word_q;
          cur_we_d    = rom_p_we_q;
          cur_tag_d   = rom_p_addr_q[23:1];
          rom_pend_d  = 1'b0;
          state_d     = ROM_ACC;
        end else if (bs_pend_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = bs_p_we_q;
          mem_addr_d  = BSRAM_BASE + {5'd0, bs_p_addr_q[19:1], 1'b0};
          mem_wdata_d = {bs_p_data_q, bs_p_data_q};
          mem_be_d    = lane_be(bs_p_we_q, 1'b0, bs_p_addr_q[0]);
          cur_sel_d   = bs_p_addr_q[0];
          cur_word_d  = 1'b0;
          cur_we_d    = bs_p_we_q;
          bs_pend_d   = 1'b0;
          state_d     = BS_ACC;
        end
      end
      ROM_ACC: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!cur_we_q) begin
            rom_out_d = rom_fmt(mem_rdata, cur_word_q, cur_sel_q);
            if (CACHE_EN) begin
              buf_vld_d  = 1'b1;
              buf_tag_d  = cur_tag_q;
              buf_data_d = mem_rdata;
            end
          end
        end
      end
      BS_ACC: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!cur_we_q) begin
            bs_out_d = cur_sel_q ? mem_rdata[15:8] : mem_rdata[7:0];
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (hit_pend_q) begin
      rom_out_d  = rom_fmt(buf_data_q, hit_word_q, hit_sel_q);
      hit_pend_d = 1'b0;
    end

    if (rom_new) begin
      if (rom_hit) begin
        hit_pend_d = 1'b1;
        hit_sel_d  = rom_addr[0];
        hit_word_d = rom_word;
        rom_pend_d = 1'b0;
      end else begin
        rom_pend_d   = 1'b1;
        rom_p_addr_d = rom_addr;
        rom_p_data_d = rom_d;
        rom_p_we_d   = !rom_we_n;
        rom_p_word_d = rom_word;
      end
      if (!rom_we_n && buf_vld_d && (buf_tag_d == rom_addr[23:1])) begin
        if (rom_word) buf_data_d = rom_d;
        else if (rom_addr[0]) buf_data_d[15:8] = rom_d[7:0];
        else buf_data_d[7:0] = rom_d[7:0];
      end
    end

    if (bs_new) begin
      bs_pend_d   = 1'b1;
      bs_p_addr_d = bsram_addr;
      bs_p_data_d = bsram_d;
      bs_p_we_d   = !bsram_we_n;
    end
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      rom_act_q       <= 1'b0;
      rom_prev_addr_q <= '0;
      rom_prev_we_n_q <= 1'b1;
      bs_act_q        <= 1'b0;
      bs_prev_addr_q  <= '0;
      bs_prev_we_n_q  <= 1'b1;
      rom_pend_q      <= 1'b0;
      rom_p_addr_q    <= '0;
      rom_p_data_q    <= '0;
      rom_p_we_q      <= 1'b0;
      rom_p_word_q    <= 1'b0;
      bs_pend_q       <= 1'b0;
      bs_p_addr_q     <= '0;
      bs_p_data_q     <= '0;
      bs_p_we_q       <= 1'b0;
      cur_sel_q       <= 1'b0;
      cur_word_q      <= 1'b0;
      cur_we_q        <= 1'b0;
      cur_tag_q       <= '0;
      buf_vld_q       <= 1'b0;
      buf_tag_q       <= '0;
      buf_data_q      <= '0;
      hit_pend_q      <= 1'b0;
      hit_sel_q       <= 1'b0;
      hit_word_q      <= 1'b0;
      rom_out_q       <= '0;
      bs_out_q        <= '0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_be_q        <= '0;
    end else begin
      state_q         <= state_d;
      rom_act_q       <= rom_act_d;
      rom_prev_addr_q <= rom_prev_addr_d;
      rom_prev_we_n_q <= rom_prev_we_n_d;
      bs_act_q        <= bs_act_d;
      bs_prev_addr_q  <= bs_prev_addr_d;
      bs_prev_we_n_q  <= bs_prev_we_n_d;
      rom_pend_q      <= rom_pend_d;
      rom_p_addr_q    <= rom_p_addr_d;
      rom_p_data_q    <= rom_p_data_d;
      rom_p_we_q      <= rom_p_we_d;
      rom_p_word_q    <= rom_p_word_d;
      bs_pend_q       <= bs_pend_d;
      bs_p_addr_q     <= bs_p_addr_d;
      bs_p_data_q     <= bs_p_data_d;
      bs_p_we_q       <= bs_p_we_d;
      cur_sel_q       <= cur_sel_d;
      cur_word_q      <= cur_word_d;
      cur_we_q        <= cur_we_d;
      cur_tag_q       <= cur_tag_d;
      buf_vld_q       <= buf_vld_d;
      buf_tag_q       <= buf_tag_d;
      buf_data_q      <= buf_data_d;
      hit_pend_q      <= hit_pend_d;
      hit_sel_q       <= hit_sel_d;
      hit_word_q      <= hit_word_d;
      rom_out_q       <= rom_out_d;
      bs_out_q        <= bs_out_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_be_q        <= mem_be_d;
    end
  end

  assign rom_q     = rom_out_q;
  assign bsram_q   = bs_out_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  // Buffer hits are deliberately left out: they never occupy the memory port.
  assign busy      = rom_pend_q || bs_pend_q || (state_q != IDLE);

endmodule

// File: tb/tb_cart_mem_responder.sv
// Directed and randomized checks of cart_mem_responder against a behavioural memory/buffer model.
module tb_cart_mem_responder;

  logic        mclk;
  logic        rst_n;
  logic [23:0] rom_addr;
  logic [15:0] rom_d;
  logic        rom_ce_n, rom_oe_n, rom_we_n, rom_word;
  logic [15:0] rom_q;
  logic [19:0] bsram_addr;
  logic [7:0]  bsram_d;
  logic        bsram_ce_n, bsram_oe_n, bsram_we_n;
  logic [7:0]  bsram_q;
  logic        mem_req, mem_we, mem_ack, busy;
  logic [24:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0]  mem_be;

  int tests;
  int fails;
  int req_cnt;
  int c0;

  cart_mem_responder dut (
    .mclk(mclk), .rst_n(rst_n),
    .rom_addr(rom_addr), .rom_d(rom_d), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n),
    .rom_we_n(rom_we_n), .rom_word(rom_word), .rom_q(rom_q),
    .bsram_addr(bsram_addr), .bsram_d(bsram_d), .bsram_ce_n(bsram_ce_n),
    .bsram_oe_n(bsram_oe_n), .bsram_we_n(bsram_we_n), .bsram_q(bsram_q),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  // Counts every rising edge of mem_req, sampled just after the clock edge.
  initial begin
    logic req_prev;
    req_prev = 1'b0;
    req_cnt  = 0;
    forever begin
      @(posedge mclk);
      #1;
      if (mem_req === 1'b1 && req_prev !== 1'b1) req_cnt++;
      req_prev = mem_req;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge mclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(mem_req), 32'd1);
  endtask

  task automatic ack(input logic [15:0] d);
    mem_ack   = 1'b1;
    mem_rdata = d;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 16'hDEAD;
  endtask

  task automatic idle_strobes();
    rom_ce_n = 1'b1; rom_oe_n = 1'b1; rom_we_n = 1'b1;
    bsram_ce_n = 1'b1; bsram_oe_n = 1'b1; bsram_we_n = 1'b1;
  endtask

  // Reference model: backing memory by word-aligned byte address, and the one-word ROM buffer.
  logic [15:0] mdl_mem [int];
  bit          mdl_vld;
  int          mdl_tag;
  logic [15:0] mdl_data;
  logic [15:0] exp_rq;
  logic [7:0]  exp_bq;

  task automatic mem_fetch(input int a, output logic [15:0] v);
    if (!mdl_mem.exists(a)) mdl_mem[a] = 16'($urandom);
    v = mdl_mem[a];
  endtask

  function automatic logic [15:0] fmt(input logic [15:0] w, input bit word, input bit hi);
    logic [7:0] b;
    if (word) return w;
    b = hi ? w[15:8] : w[7:0];
    return {b, b};
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] be);
    return {be[1] ? nw[15:8] : old[15:8], be[0] ? nw[7:0] : old[7:0]};
  endfunction

  bit          rnd_rom, rnd_wr, rnd_word, rnd_hit, sel;
  logic [23:0] ra;
  logic [19:0] ba;
  logic [15:0] rd16, wexp, word_v;
  logic [1:0]  be_exp;
  int          wa;

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 16'hDEAD;
    rom_addr = 24'h0; rom_d = 16'h0; rom_word = 1'b0;
    bsram_addr = 20'h0; bsram_d = 8'h0;
    idle_strobes();
    rom_ce_n = 1'b0; rom_oe_n = 1'b0;

    // Reset held with an active ROM strobe and a toggling ack.
    for (int i = 0; i < 4; i++) begin
      mem_ack = ~mem_ack;
      tick();
      chk("rst_req", 32'(mem_req), 32'd0);
    end
    chk("rst_rom_q", 32'(rom_q), 32'd0);
    chk("rst_bsram_q", 32'(bsram_q), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    mem_ack = 1'b0;
    idle_strobes();
    rst_n = 1'b1;
    tick(2);

    // ROM byte read miss, acked three cycles after the request.
    rom_addr = 24'h008001; rom_word = 1'b0; rom_ce_n = 1'b0; rom_oe_n = 1'b0;
    tick();
    chk("miss_busy", 32'(busy), 32'd1);
    chk("miss_req_early", 32'(mem_req), 32'd0);
    tick();
    chk("miss_req", 32'(mem_req), 32'd1);
    chk("miss_addr", 32'(mem_addr), 32'h0008000);
    chk("miss_we", 32'(mem_we), 32'd0);
    chk("miss_be", 32'(mem_be), 32'd3);
    tick(2);
    ack(16'hBEEF);
    chk("miss_rom_q", 32'(rom_q), 32'h0000BEBE);
    chk("miss_req_drop", 32'(mem_req), 32'd0);
    chk("miss_busy_drop", 32'(busy), 32'd0);

    // Same word, other byte: buffer hit.
    c0 = req_cnt;
    rom_addr = 24'h008000;
    tick();
    chk("hit_early", 32'(rom_q), 32'h0000BEBE);
    chk("hit_busy", 32'(busy), 32'd0);
    tick();
    chk("hit_rom_q", 32'(rom_q), 32'h0000EFEF);
    chk("hit_noreq", 32'(req_cnt), 32'(c0));

    // Word write into the buffered word, then read it back from the buffer.
    rom_word = 1'b1; rom_d = 16'h1234; rom_oe_n = 1'b1; rom_we_n = 1'b0;
    tick(2);
    chk("wr_req", 32'(mem_req), 32'd1);
    chk("wr_we", 32'(mem_we), 32'd1);
    chk("wr_be", 32'(mem_be), 32'd3);
    chk("wr_wdata", 32'(mem_wdata), 32'h1234);
    chk("wr_addr", 32'(mem_addr), 32'h0008000);
    ack(16'h0000);
    chk("wr_rom_q_kept", 32'(rom_q), 32'h0000EFEF);
    c0 = req_cnt;
    rom_we_n = 1'b1; rom_oe_n = 1'b0;
    tick(2);
    chk("bufupd_rom_q", 32'(rom_q), 32'h1234);
    chk("bufupd_noreq", 32'(req_cnt), 32'(c0));

    // ROM read and BSRAM write detected together: ROM goes first.
    rom_addr = 24'h024680;
    bsram_addr = 20'h00003; bsram_d = 8'h5A; bsram_ce_n = 1'b0; bsram_we_n = 1'b0;
    tick(2);
    chk("col_req1", 32'(mem_req), 32'd1);
    chk("col_addr1", 32'(mem_addr), 32'h0024680);
    chk("col_we1", 32'(mem_we), 32'd0);
    ack(16'h1357);
    chk("col_rom_q", 32'(rom_q), 32'h1357);
    tick();
    chk("col_req2", 32'(mem_req), 32'd1);
    chk("col_addr2", 32'(mem_addr), 32'h1000002);
    chk("col_be2", 32'(mem_be), 32'd2);
    chk("col_wdata2", 32'(mem_wdata), 32'h5A5A);
    chk("col_we2", 32'(mem_we), 32'd1);
    ack(16'h0000);
    chk("col_busy", 32'(busy), 32'd0);
    chk("col_bsram_q", 32'(bsram_q), 32'd0);

    // Three ROM address changes while a BSRAM read is outstanding.
    bsram_addr = 20'h00011; bsram_we_n = 1'b1; bsram_oe_n = 1'b0;
    tick(2);
    chk("ovr_bs_addr", 32'(mem_addr), 32'h1000010);
    c0 = req_cnt;
    rom_addr = 24'h030000; tick();
    rom_addr = 24'h030002; tick();
    rom_addr = 24'h030004; tick();
    chk("ovr_bs_held", 32'(mem_addr), 32'h1000010);
    ack(16'hABCD);
    chk("ovr_bsram_q", 32'(bsram_q), 32'h00AB);
    tick();
    chk("ovr_rom_req", 32'(mem_req), 32'd1);
    chk("ovr_rom_addr", 32'(mem_addr), 32'h0030004);
    ack(16'h1111);
    chk("ovr_rom_q", 32'(rom_q), 32'h1111);
    tick(3);
    chk("ovr_one_req", 32'(req_cnt), 32'(c0 + 1));
    chk("ovr_busy", 32'(busy), 32'd0);

    // One-cycle reset while a ROM request is outstanding, followed by a late ack.
    rom_addr = 24'h040000;
    tick(2);
    chk("rmid_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    idle_strobes();
    tick();
    chk("rmid_req_drop", 32'(mem_req), 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    ack(16'hFFFF);
    tick();
    chk("rmid_rom_q", 32'(rom_q), 32'd0);
    chk("rmid_req_idle", 32'(mem_req), 32'd0);

    // Randomized single transactions against the model.
    mdl_vld = 1'b0; mdl_tag = -1; mdl_data = 16'h0;
    exp_rq = 16'h0; exp_bq = 8'h0;
    for (int t = 0; t < 120; t++) begin
      rnd_rom  = ($urandom_range(0, 2) != 0);
      rnd_wr   = ($urandom_range(0, 3) == 0);
      rnd_word = 1'($urandom_range(0, 1));
      rd16     = 16'($urandom);
      ra       = 24'h000200 + 24'($urandom_range(0, 7));
      ba       = 20'($urandom_range(0, 7));
      if (rnd_rom) begin
        wa  = int'(ra) / 2 * 2;
        sel = ra[0];
      end else begin
        wa  = 32'h1000000 + int'(ba) / 2 * 2;
        sel = ba[0];
      end
      wexp = 16'h0;
      if (!rnd_wr) be_exp = 2'b11;
      else if (rnd_rom && rnd_word) begin be_exp = 2'b11; wexp = rd16; end
      else begin be_exp = sel ? 2'b10 : 2'b01; wexp = {rd16[7:0], rd16[7:0]}; end

      idle_strobes();
      tick();
      if (rnd_rom) begin
        rom_addr = ra; rom_d = rd16; rom_word = rnd_word;
        rom_ce_n = 1'b0; rom_oe_n = rnd_wr; rom_we_n = !rnd_wr;
      end else begin
        bsram_addr = ba; bsram_d = rd16[7:0];
        bsram_ce_n = 1'b0; bsram_oe_n = rnd_wr; bsram_we_n = !rnd_wr;
      end
      c0 = req_cnt;
      rnd_hit = rnd_rom && !rnd_wr && mdl_vld && (mdl_tag == wa);
      tick();
      if (rnd_hit) begin
        chk("rnd_hit_busy", 32'(busy), 32'd0);
        tick();
        exp_rq = fmt(mdl_data, rnd_word, sel);
        chk("rnd_hit_rom_q", 32'(rom_q), 32'(exp_rq));
        chk("rnd_hit_noreq", 32'(req_cnt), 32'(c0));
      end else begin
        chk("rnd_busy", 32'(busy), 32'd1);
        wait_req();
        chk("rnd_addr", 32'(mem_addr), 32'(wa));
        chk("rnd_we", 32'(mem_we), 32'(rnd_wr));
        chk("rnd_be", 32'(mem_be), 32'(be_exp));
        if (rnd_wr) chk("rnd_wdata", 32'(mem_wdata), 32'(wexp));
        tick($urandom_range(0, 3));
        mem_fetch(wa, word_v);
        ack(rnd_wr ? 16'hDEAD : word_v);
        if (rnd_wr) begin
          mdl_mem[wa] = merge(word_v, wexp, be_exp);
          if (rnd_rom && mdl_vld && mdl_tag == wa) mdl_data = merge(mdl_data, wexp, be_exp);
        end else if (rnd_rom) begin
          exp_rq   = fmt(word_v, rnd_word, sel);
          mdl_vld  = 1'b1;
          mdl_tag  = wa;
          mdl_data = word_v;
        end else begin
          exp_bq = sel ? word_v[15:8] : word_v[7:0];
        end
        chk("rnd_rom_q", 32'(rom_q), 32'(exp_rq));
        chk("rnd_bsram_q", 32'(bsram_q), 32'(exp_bq));
        chk("rnd_req_drop", 32'(mem_req), 32'd0);
        chk("rnd_busy_drop", 32'(busy), 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
